// File: rtl/base_target.sv
// base_target: stationary player-base sprite with hit points.
//
// Pixel side (combinational from x/y):
//   sprite_on            - pixel inside the sprite square and base not destroyed
//   sprite_row/col       - ROM address, offset from the sprite corner, truncated
// Frame side (registered, updated on the refresh_tick edge):
//   hit_bullet           - one-cycle per-channel pulse for every bullet that hit
//   hp                   - remaining hit points
//   exploding            - explosion animation running
//   explode_frame        - explosion animation frame index
//   destroyed            - sticky defeat flag, cleared only by reset
// Inputs:
//   clk_50MHz, reset (asynchronous, active-low), x/y pixel position,
//   refresh_tick (one pulse per frame), bullet_valid/x_bullets/y_bullets
//   (channel i packed at [10i+9:10i]).
// Optional feature macro BASE_TARGET_SHIELD_EN: after each accepted hit the
// base is invulnerable for SHIELD_FRAMES frames; adds output shield_on.
module base_target #(
  parameter int NUM_BULLETS    = 4,
  parameter int SPRITE_SIZE    = 32,
  parameter int BULLET_SIZE    = 4,
  parameter int HP_MAX         = 3,
  parameter int EXPLODE_FRAMES = 16,
  parameter int SHIELD_FRAMES  = 30,
  parameter int X_START        = 320,
  parameter int Y_START        = 240
) (
  input  logic                           clk_50MHz,
  input  logic                           reset,
  input  logic [9:0]                     x,
  input  logic [9:0]                     y,
  input  logic                           refresh_tick,
  input  logic [NUM_BULLETS-1:0]         bullet_valid,
  input  logic [10*NUM_BULLETS-1:0]      x_bullets,
  input  logic [10*NUM_BULLETS-1:0]      y_bullets,
  output logic [9:0]                     x_pos,
  output logic [9:0]                     y_pos,
  output logic                           sprite_on,
  output logic [$clog2(SPRITE_SIZE)-1:0] sprite_row,
  output logic [$clog2(SPRITE_SIZE)-1:0] sprite_col,
  output logic [3:0]                     hp,
  output logic [NUM_BULLETS-1:0]         hit_bullet,
  output logic                           exploding,
  output logic [7:0]                     explode_frame,
  output logic                           destroyed
`ifdef BASE_TARGET_SHIELD_EN
  ,
  output logic                           shield_on
`endif
);

  localparam int ADDR_W = $clog2(SPRITE_SIZE);
  localparam logic [10:0] SIZE_M1   = 11'(SPRITE_SIZE - 1);
  localparam logic [10:0] BULLET_M1 = 11'(BULLET_SIZE - 1);
  localparam logic [7:0]  LAST_FRAME = 8'(EXPLODE_FRAMES - 1);

  typedef enum logic [1:0] {
    ALIVE,
    EXPLODING,
    DESTROYED
  } state_t;

  state_t                 state, state_nxt;
  logic [3:0]             hp_nxt;
  logic [NUM_BULLETS-1:0] hit_nxt;
  logic [7:0]             frame_nxt;
  logic [NUM_BULLETS-1:0] coll;
  logic                   shield_block;

  logic [10:0] x_end, y_end;
  logic [9:0]  dx, dy;

  // ---------------------------------------------------------------------
  // Position: loaded at reset, never changes afterwards.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      x_pos <= 10'(X_START);
      y_pos <= 10'(Y_START);
    end else begin
      x_pos <= x_pos;
      y_pos <= y_pos;
    end
  end

  // Far edges widened to 11 bits so a sprite near the screen edge cannot wrap.
  assign x_end = {1'b0, x_pos} + SIZE_M1;
  assign y_end = {1'b0, y_pos} + SIZE_M1;

  // ---------------------------------------------------------------------
  // Pixel side
  // ---------------------------------------------------------------------
  assign dx = x - x_pos;
  assign dy = y - y_pos;
  assign sprite_col = dx[ADDR_W-1:0];
  assign sprite_row = dy[ADDR_W-1:0];

  always_comb begin
    sprite_on = ({1'b0, x} >= {1'b0, x_pos}) && ({1'b0, x} <= x_end) &&
                ({1'b0, y} >= {1'b0, y_pos}) && ({1'b0, y} <= y_end) &&
                (state != DESTROYED);
  end

  // ---------------------------------------------------------------------
  // Bullet / sprite overlap test, one bit per channel
  // ---------------------------------------------------------------------
  always_comb begin
    logic [10:0] bx, by;
    coll = '0;
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      bx = {1'b0, x_bullets[10*i +: 10]};
      by = {1'b0, y_bullets[10*i +: 10]};
      coll[i] = bullet_valid[i] &&
                (bx <= x_end) && (bx + BULLET_M1 >= {1'b0, x_pos}) &&
                (by <= y_end) && (by + BULLET_M1 >= {1'b0, y_pos});
    end
  end

  // ---------------------------------------------------------------------
  // Shield counter (optional)
  // ---------------------------------------------------------------------
`ifdef BASE_TARGET_SHIELD_EN
  localparam int SW = (SHIELD_FRAMES < 1) ? 1 : $clog2(SHIELD_FRAMES + 1);

  logic [SW-1:0] shield_cnt, shield_nxt;

  // The block decision uses the count before this tick's decrement.
  assign shield_block = (shield_cnt != '0);
  assign shield_on    = (shield_cnt != '0);

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) shield_cnt <= '0;
    else        shield_cnt <= shield_nxt;
  end
`else
  assign shield_block = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Frame FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state         <= ALIVE;
      hp            <= 4'(HP_MAX);
      hit_bullet    <= '0;
      explode_frame <= '0;
    end else begin
      state         <= state_nxt;
      hp            <= hp_nxt;
      hit_bullet    <= hit_nxt;
      explode_frame <= frame_nxt;
    end
  end

  assign exploding = (state == EXPLODING);
  assign destroyed = (state == DESTROYED);

  // ---------------------------------------------------------------------
  // Frame FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    hp_nxt    = hp;
    hit_nxt   = '0;
    frame_nxt = explode_frame;
`ifdef BASE_TARGET_SHIELD_EN
    shield_nxt = shield_cnt;
`endif
    if (refresh_tick) begin
`ifdef BASE_TARGET_SHIELD_EN
      if (shield_cnt != '0) shield_nxt = shield_cnt - SW'(1);
`endif
      case (state)
        ALIVE: begin
          if ((coll != '0) && !shield_block) begin
            hit_nxt = coll;
            hp_nxt  = hp - 4'd1;
`ifdef BASE_TARGET_SHIELD_EN
            shield_nxt = SW'(SHIELD_FRAMES);
`endif
            if (hp == 4'd1) begin
              state_nxt = EXPLODING;
              frame_nxt = '0;
            end
          end
        end
        EXPLODING: begin
          if (explode_frame == LAST_FRAME) state_nxt = DESTROYED;
          else                             frame_nxt = explode_frame + 8'd1;
        end
        DESTROYED: begin
          state_nxt = DESTROYED;
        end
        default: begin
          state_nxt = ALIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_base_target.sv
module tb_base_target;

  localparam int NB = 4;
`ifdef BASE_TARGET_SHIELD_EN
  localparam bit SHIELD = 1'b1;
`else
  localparam bit SHIELD = 1'b0;
`endif

  logic            clk_50MHz = 1'b0;
  logic            reset = 1'b0;
  logic [9:0]      x = '0, y = '0;
  logic            refresh_tick = 1'b0;
  logic [NB-1:0]   bullet_valid = '0;
  logic [10*NB-1:0] x_bullets = '0, y_bullets = '0;
  logic [9:0]      x_pos, y_pos;
  logic            sprite_on;
  logic [4:0]      sprite_row, sprite_col;
  logic [3:0]      hp;
  logic [NB-1:0]   hit_bullet;
  logic            exploding;
  logic [7:0]      explode_frame;
  logic            destroyed;
`ifdef BASE_TARGET_SHIELD_EN
  logic            shield_on;
`endif

  base_target #(
    .NUM_BULLETS(NB), .SPRITE_SIZE(32), .BULLET_SIZE(4), .HP_MAX(3),
    .EXPLODE_FRAMES(16), .SHIELD_FRAMES(30), .X_START(320), .Y_START(240)
  ) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .x(x), .y(y),
    .refresh_tick(refresh_tick), .bullet_valid(bullet_valid),
    .x_bullets(x_bullets), .y_bullets(y_bullets),
    .x_pos(x_pos), .y_pos(y_pos), .sprite_on(sprite_on),
    .sprite_row(sprite_row), .sprite_col(sprite_col), .hp(hp),
    .hit_bullet(hit_bullet), .exploding(exploding),
    .explode_frame(explode_frame), .destroyed(destroyed)
`ifdef BASE_TARGET_SHIELD_EN
    , .shield_on(shield_on)
`endif
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The base is a rectangle [320,351]x[240,271]; a bullet is a 4x4 square.
  int        m_hp, m_frame, m_sh;
  bit        m_boom, m_dead;
  logic [3:0] m_hit;

  task automatic model_reset();
    m_hp = 3; m_frame = 0; m_sh = 0; m_boom = 0; m_dead = 0; m_hit = '0;
  endtask

  function automatic logic [3:0] model_coll(input logic [3:0] v,
                                            input logic [39:0] xb, input logic [39:0] yb);
    logic [3:0] r;
    int bx, by;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      bx = int'(xb[10*i +: 10]);
      by = int'(yb[10*i +: 10]);
      if (v[i] && bx <= 351 && bx + 3 >= 320 && by <= 271 && by + 3 >= 240) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step();
    logic [3:0] c;
    bit blk;
    m_hit = '0;
    if (refresh_tick) begin
      c = model_coll(bullet_valid, x_bullets, y_bullets);
      blk = SHIELD && (m_sh > 0);
      if (SHIELD && m_sh > 0) m_sh--;
      if (m_dead) begin
      end else if (m_boom) begin
        if (m_frame == 15) begin m_boom = 0; m_dead = 1; end
        else m_frame++;
      end else if (!blk && c != 0) begin
        m_hit = c;
        m_hp--;
        if (SHIELD) m_sh = 30;
        if (m_hp == 0) begin m_boom = 1; m_frame = 0; end
      end
    end
  endtask

  function automatic bit model_on(input int px, input int py);
    return px >= 320 && px <= 351 && py >= 240 && py <= 271 && !m_dead;
  endfunction

  // ---------------- drive helpers (called at negedge) ----------------
  task automatic put(input logic tick, input logic [3:0] v,
                     input logic [39:0] xb, input logic [39:0] yb);
    refresh_tick = tick; bullet_valid = v; x_bullets = xb; y_bullets = yb;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
  endtask

  task automatic do_reset();
    put(1'b0, '0, '0, '0);
    reset = 1'b0;
    model_reset();
    #5 reset = 1'b1;
    @(negedge clk_50MHz);
  endtask

  localparam logic [39:0] HX = 40'd330;
  localparam logic [39:0] HY = 40'd250;

  typedef struct {
    logic [3:0]  valid;
    logic [39:0] xb;
    logic [39:0] yb;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [3:0]  exp_hit;
    logic [3:0]  exp_hp;
    logic        exp_on;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // packing {ch3, ch2, ch1, ch0}
    tbl[0]  = '{4'b0010, {10'd0, 10'd0, 10'd316, 10'd0}, {10'd0, 10'd0, 10'd250, 10'd0}, 10'd330, 10'd250, 4'b0000, 4'd3, 1'b1};
    tbl[1]  = '{4'b0010, {10'd0, 10'd0, 10'd317, 10'd0}, {10'd0, 10'd0, 10'd250, 10'd0}, 10'd320, 10'd240, 4'b0010, 4'd2, 1'b1};
    tbl[2]  = '{4'b0010, {10'd0, 10'd0, 10'd352, 10'd0}, {10'd0, 10'd0, 10'd250, 10'd0}, 10'd351, 10'd271, 4'b0000, 4'd3, 1'b1};
    tbl[3]  = '{4'b0010, {10'd0, 10'd0, 10'd351, 10'd0}, {10'd0, 10'd0, 10'd250, 10'd0}, 10'd352, 10'd250, 4'b0010, 4'd2, 1'b0};
    tbl[4]  = '{4'b0001, 40'd330, 40'd236, 10'd319, 10'd250, 4'b0000, 4'd3, 1'b0};
    tbl[5]  = '{4'b0001, 40'd330, 40'd237, 10'd330, 10'd239, 4'b0001, 4'd2, 1'b0};
    tbl[6]  = '{4'b0001, 40'd330, 40'd272, 10'd330, 10'd272, 4'b0000, 4'd3, 1'b0};
    tbl[7]  = '{4'b0001, 40'd330, 40'd271, 10'd330, 10'd271, 4'b0001, 4'd2, 1'b1};
    tbl[8]  = '{4'b0101, {10'd0, 10'd340, 10'd0, 10'd330}, {10'd0, 10'd260, 10'd0, 10'd250}, 10'd340, 10'd260, 4'b0101, 4'd2, 1'b1};
    tbl[9]  = '{4'b0000, {10'd0, 10'd340, 10'd0, 10'd330}, {10'd0, 10'd260, 10'd0, 10'd250}, 10'd0,   10'd0,   4'b0000, 4'd3, 1'b0};
    tbl[10] = '{4'b1000, {10'd330, 10'd0, 10'd0, 10'd330}, {10'd250, 10'd0, 10'd0, 10'd250}, 10'd600, 10'd479, 4'b1000, 4'd2, 1'b0};
    tbl[11] = '{4'b1111, {10'd348, 10'd320, 10'd330, 10'd340}, {10'd268, 10'd240, 10'd250, 10'd255}, 10'd335, 10'd255, 4'b1111, 4'd2, 1'b1};

    model_reset();
    repeat (2) @(negedge clk_50MHz);
    reset = 1'b1;
    @(negedge clk_50MHz);

    // ---- reset state ----
    check("rst_x_pos", x_pos, 320);
    check("rst_y_pos", y_pos, 240);
    check("rst_hp", hp, 3);
    check("rst_hit", hit_bullet, 0);
    check("rst_exploding", exploding, 0);
    check("rst_frame", explode_frame, 0);
    check("rst_destroyed", destroyed, 0);
`ifdef BASE_TARGET_SHIELD_EN
    check("rst_shield", shield_on, 0);
`endif

    // ---- ROM address truncation ----
    x = 10'd330; y = 10'd250; #1;
    check("col_mid", sprite_col, 10); check("row_mid", sprite_row, 10);
    x = 10'd351; y = 10'd271; #1;
    check("col_end", sprite_col, 31); check("row_end", sprite_row, 31);
    x = 10'd300; y = 10'd200; #1;
    check("col_wrap", sprite_col, 12); check("row_wrap", sprite_row, 24);
    @(negedge clk_50MHz);

    // ---- collisions without refresh_tick are ignored ----
    put(1'b0, 4'b0001, HX, HY);
    advance(); advance();
    check("notick_hit", hit_bullet, 0);
    check("notick_hp", hp, 3);

    // ---- first hit and one-cycle pulse ----
    put(1'b1, 4'b0001, HX, HY);
    advance();
    check("hit1_hp", hp, 2);
    check("hit1_pulse", hit_bullet, 4'b0001);
    put(1'b0, 4'b0001, HX, HY);
    advance();
    check("hit1_pulse_end", hit_bullet, 0);

    // ---- table of single-tick vectors, each from reset ----
    for (int i = 0; i < 12; i++) begin
      do_reset();
      x = tbl[i].px; y = tbl[i].py;
      put(1'b1, tbl[i].valid, tbl[i].xb, tbl[i].yb);
      advance();
      check($sformatf("tbl%0d_hit", i), hit_bullet, tbl[i].exp_hit);
      check($sformatf("tbl%0d_hp", i), hp, tbl[i].exp_hp);
      check($sformatf("tbl%0d_on", i), sprite_on, tbl[i].exp_on);
      put(1'b0, tbl[i].valid, tbl[i].xb, tbl[i].yb);
      advance();
      check($sformatf("tbl%0d_clr", i), hit_bullet, 0);
      check($sformatf("tbl%0d_hold", i), hp, tbl[i].exp_hp);
    end

`ifndef BASE_TARGET_SHIELD_EN
    // ---- defeat, explosion, destruction ----
    do_reset();
    x = 10'd330; y = 10'd250;
    for (int k = 0; k < 3; k++) begin
      put(1'b1, 4'b0001, HX, HY);
      advance();
      check("kill_hp", hp, 2 - k);
      check("kill_hit", hit_bullet, 4'b0001);
    end
    check("boom_start", exploding, 1);
    check("boom_frame0", explode_frame, 0);
    for (int k = 1; k <= 15; k++) begin
      put(1'b1, 4'b0001, HX, HY);
      advance();
      check("boom_frame", explode_frame, k);
      check("boom_nohit", hit_bullet, 0);
      check("boom_flag", exploding, 1);
    end
    put(1'b1, 4'b0001, HX, HY);
    advance();
    check("dead_flag", destroyed, 1);
    check("dead_noboom", exploding, 0);
    check("dead_sprite_off", sprite_on, 0);
    put(1'b1, 4'b0001, HX, HY);
    advance();
    check("dead_nohit", hit_bullet, 0);
    check("dead_sticky", destroyed, 1);

    // ---- asynchronous reset mid-explosion ----
    do_reset();
    for (int k = 0; k < 10; k++) begin
      put(1'b1, 4'b0001, HX, HY);
      advance();
    end
    check("mid_frame7", explode_frame, 7);
    put(1'b0, '0, '0, '0);
    #3 reset = 1'b0;
    #1;
    model_reset();
    check("areset_hp", hp, 3);
    check("areset_exploding", exploding, 0);
    check("areset_frame", explode_frame, 0);
    check("areset_destroyed", destroyed, 0);
    check("areset_on", sprite_on, 1);
    #1 reset = 1'b1;
    @(negedge clk_50MHz);
`else
    // ---- shield window ----
    do_reset();
    put(1'b1, 4'b0001, HX, HY);
    advance();
    check("sh_hp", hp, 2);
    check("sh_on", shield_on, 1);
    for (int k = 1; k <= 30; k++) begin
      put(1'b1, 4'b0001, HX, HY);
      advance();
      check("sh_pass", hit_bullet, 0);
      check("sh_hp_hold", hp, 2);
      check("sh_flag", shield_on, (k < 30) ? 1 : 0);
    end
    put(1'b1, 4'b0001, HX, HY);
    advance();
    check("sh_after_hp", hp, 1);
    check("sh_after_hit", hit_bullet, 4'b0001);
`endif

    // ---- randomized run against the model ----
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [39:0] xb, yb;
      int px, py;
      for (int i = 0; i < NB; i++) begin
        xb[10*i +: 10] = 10'($urandom_range(310, 360));
        yb[10*i +: 10] = 10'($urandom_range(230, 280));
      end
      px = int'($urandom_range(310, 360));
      py = int'($urandom_range(230, 280));
      x = 10'(px); y = 10'(py);
      put(1'(($urandom % 2) == 0), 4'($urandom), xb, yb);
      advance();
      check("rnd_hit", hit_bullet, m_hit);
      check("rnd_hp", hp, m_hp);
      check("rnd_exploding", exploding, m_boom);
      check("rnd_destroyed", destroyed, m_dead);
      if (m_boom) check("rnd_frame", explode_frame, m_frame);
      check("rnd_on", sprite_on, model_on(px, py));
`ifdef BASE_TARGET_SHIELD_EN
      check("rnd_shield", shield_on, m_sh != 0);
`endif
      if (m_dead && ($urandom % 8) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/base_target.md
Name: base_target

Overview:
- Stationary, parametrised player-base sprite (the successor to the fixed single-hit base).
- Provides the pixel-side hit mask and ROM row/col addresses to the VGA mixer.
- Checks NUM_BULLETS bullet channels for collision once per frame and tracks hit points.
- On defeat, runs an explosion animation, then stays destroyed until reset.

Parameters:
- NUM_BULLETS, 4: number of bullet channels checked.
- SPRITE_SIZE, 32: sprite edge in pixels; power of 2, range 8..64.
- BULLET_SIZE, 4: bullet square edge in pixels.
- HP_MAX, 3: hit points at reset; range 1..15.
- EXPLODE_FRAMES, 16: explosion duration in frames; range 1..256.
- SHIELD_FRAMES, 30: invulnerability window after a hit; used only with the optional feature.
- X_START, 320: fixed left edge of the sprite.
- Y_START, 240: fixed top edge of the sprite.

Ports:
- clk_50MHz, input, 1: system clock.
- reset, input, 1: asynchronous, active-low.
- x, input, 10: current pixel column from the VGA controller.
- y, input, 10: current pixel row from the VGA controller.
- refresh_tick, input, 1: one-cycle pulse, once per frame.
- bullet_valid, input, NUM_BULLETS: per-channel bullet-alive flag.
- x_bullets, input, 10*NUM_BULLETS: packed bullet left edges; channel i at [10i+9:10i].
- y_bullets, input, 10*NUM_BULLETS: packed bullet top edges, same packing.
- x_pos, output, 10: sprite left edge.
- y_pos, output, 10: sprite top edge.
- sprite_on, output, 1: current pixel lies inside the visible sprite.
- sprite_row, output, $clog2(SPRITE_SIZE): ROM row address, y - y_pos, truncated.
- sprite_col, output, $clog2(SPRITE_SIZE): ROM column address, x - x_pos, truncated.
- hp, output, 4: remaining hit points.
- hit_bullet, output, NUM_BULLETS: one-cycle per-channel pulse so the bullet owner can kill that bullet.
- exploding, output, 1: high during the explosion.
- explode_frame, output, 8: explosion animation frame index.
- destroyed, output, 1: sticky defeat flag.

Behaviour:
- Reset: asynchronous, active-low; clock clk_50MHz. Reset values:
  - x_pos=X_START, y_pos=Y_START
  - hp=HP_MAX, state=ALIVE
  - hit_bullet=0, exploding=0, explode_frame=0, destroyed=0
  - shield counter=0
- Reset asserted mid-operation, in any state, returns all of the above immediately.
- Position never changes after reset.
- Pixel side, combinational from x and y:
  - sprite_on = x_pos<=x<=x_pos+SPRITE_SIZE-1 and y_pos<=y<=y_pos+SPRITE_SIZE-1, and state!=DESTROYED.
  - Compares use 11-bit arithmetic; no wrap.
- Collision for channel i: bullet_valid[i] and bx<=x_pos+SPRITE_SIZE-1 and bx+BULLET_SIZE-1>=x_pos, plus the same test on y. Uses 11-bit sums.
- Collision is sampled only on the clk edge where refresh_tick=1. All registered outputs update at that edge and are visible the following cycle.
- State ALIVE, on a refresh_tick edge with at least one colliding channel:
  - hit_bullet = collision vector, pulsed for exactly one cycle (all colliding channels flagged).
  - hp decrements by exactly 1, regardless of how many channels collide.
  - If hp was 1, go to EXPLODING: hp=0, exploding=1, explode_frame=0.
- State EXPLODING: collisions are ignored and hit_bullet stays 0. Each refresh_tick increments explode_frame. On the tick where explode_frame=EXPLODE_FRAMES-1, go to DESTROYED.
- State DESTROYED: exploding=0, destroyed=1, sprite_on=0, collisions ignored. Terminal until reset.
- hit_bullet is 0 in every cycle not immediately following a qualifying refresh_tick.
- Bullet inputs are don't-care when refresh_tick=0.

Optional Feature:
- Macro: BASE_TARGET_SHIELD_EN.
- Defined:
  - Each accepted hit loads the shield counter with SHIELD_FRAMES.
  - Each refresh_tick decrements the counter when it is non-zero; the decrement happens on the same edge the collision test is made.
  - Collisions on a tick where the counter is non-zero before the decrement are ignored, and hit_bullet stays 0 (bullets pass through).
  - Extra output shield_on, 1 bit, = counter!=0.
- Undefined: no counter, no shield_on port; every qualifying tick is a hit.

Test Plan:
- After reset, ch0 valid at (330,250) with a refresh_tick pulse -> next cycle hp=2, hit_bullet=4'b0001; the cycle after, hit_bullet=0.
- Edge case, x_bullets ch1=316, y=250, tick -> no hit, hp=3. Repeat with ch1 x=317 -> hit, hp=2. Repeat with x=352 -> no hit; x=351 -> hit.
- ch0 at (330,250) and ch2 at (340,260) both valid on one tick -> hp=3 to 2 (one decrement), hit_bullet=4'b0101. Same positions with bullet_valid=0 -> nothing.
- Three hits on separate ticks (shield macro off):
  - exploding=1 and hp=0 after the third.
  - explode_frame counts 0..15 over the next 15 ticks.
  - The 16th tick gives destroyed=1, sprite_on=0 for x=330,y=250.
  - Further hits -> hit_bullet=0.
- Reset pulsed low mid-explosion (explode_frame=7) -> immediately hp=3, exploding=0, explode_frame=0, destroyed=0, sprite_on=1 at (330,250).
- With BASE_TARGET_SHIELD_EN:
  - A hit gives hp=2, shield_on=1.
  - A collision on each of the next 30 ticks is ignored (hit_bullet=0); shield_on drops after the 30th.
  - A collision on the 31st tick gives hp=1.
